// File: rtl/seg_scan_display_if.sv
// Bundle between the clock datapath and the multiplexed 7-segment scan driver.
// The datapath side drives the digit/mask inputs; the driver returns the pin-level AN/C/DP lines.
interface seg_scan_display_if #(
  parameter int N_DIG = 8
);
  logic [4*N_DIG-1:0] iD;
  logic [N_DIG-1:0]   DOT;
  logic [N_DIG-1:0]   BLANK;
  logic [N_DIG-1:0]   BLINK;
  logic               LZB;
  logic [N_DIG-1:0]   AN;
  logic [6:0]         C;
  logic               DP;
  logic               SCAN_TICK;

  modport master (
    output iD, DOT, BLANK, BLINK, LZB,
    input  AN, C, DP, SCAN_TICK
  );

  modport slave (
    input  iD, DOT, BLANK, BLINK, LZB,
    output AN, C, DP, SCAN_TICK
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver: one digit per slot, guard-band anti-ghosting,
// blinking, leading-zero blanking and a shadow copy of the inputs taken once per frame.
module seg_scan_display #(
  parameter int N_DIG          = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 2,
  parameter int BLINK_DIV      = 250,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                CP_1MHz,
  input  logic                nCLR,
  seg_scan_display_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic [N_DIG-1:0] AN_POL  = {N_DIG{AN_ACTIVE_LOW}};
  localparam logic [6:0]       SEG_POL = {7{SEG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    unique case (v)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             tick;
  logic             frame_end;

  // Frame shadow of the inputs
  logic [3:0]       sh_nib [N_DIG];
  logic [N_DIG-1:0] sh_dot;
  logic [N_DIG-1:0] sh_blank;
  logic [N_DIG-1:0] sh_blink;
  logic             sh_lzb;

  // Per-slot decode
  logic [N_DIG-1:0] lead_zero;
  logic             zero_run;
  logic             in_guard;
  logic             en;
  logic             seg_on;
  logic             dp_on;
  logic [N_DIG-1:0] an_act;
  logic [6:0]       c_act;
  logic             dp_act;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // NOTE: all registers use non-blocking assignments so each one samples pre-edge values,
  // independent of the order of statements or blocks.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      cnt         <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Inputs are captured only at the slot boundary that starts a new frame, so a
  // value changed mid-frame never shows as a mix of old and new digits.
  // NOTE: the shadow array is reset element by element because the first frame after
  // reset must display a defined all-zero value, not whatever the flops powered up to.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      for (int i = 0; i < N_DIG; i++) sh_nib[i] <= 4'h0;
      sh_dot   <= '0;
      sh_blank <= '0;
      sh_blink <= '0;
      sh_lzb   <= 1'b0;
    end else if (frame_end) begin
      for (int i = 0; i < N_DIG; i++) sh_nib[i] <= bus.iD[4*i +: 4];
      sh_dot   <= bus.DOT;
      sh_blank <= bus.BLANK;
      sh_blink <= bus.BLINK;
      sh_lzb   <= bus.LZB;
    end
  end

  // Digit i>0 is a leading zero when it and every digit to its left are zero.
  // NOTE: every always_comb output gets a default before any conditional logic,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      zero_run     = zero_run && (sh_nib[i] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    in_guard = (int'(cnt) < GUARD);
    en       = !sh_blank[idx] && !(sh_blink[idx] && blink_phase);
    seg_on   = en && !(sh_lzb && lead_zero[idx]);
    dp_on    = en && sh_dot[idx];
    an_act   = '0;
    c_act    = 7'h00;
    dp_act   = 1'b0;
    if (!in_guard) begin
      an_act = N_DIG'(1) << idx;
      c_act  = seg_on ? hex_font(sh_nib[idx]) : 7'h00;
      dp_act = dp_on;
    end
  end

  // Registered pin drive; polarity is folded in on the final stage.
  always_ff @(posedge CP_1MHz or negedge nCLR) begin
    if (!nCLR) begin
      bus.AN        <= AN_POL;
      bus.C         <= SEG_POL;
      bus.DP        <= SEG_ACTIVE_LOW;
      bus.SCAN_TICK <= 1'b0;
    end else begin
      bus.AN        <= an_act ^ AN_POL;
      bus.C         <= c_act ^ SEG_POL;
      bus.DP        <= dp_act ^ SEG_ACTIVE_LOW;
      bus.SCAN_TICK <= tick;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle-indexed reference model queues the expected
// pin state for every clock, and an independent monitor pops and compares on the falling edge.
module tb_seg_scan_display;

  localparam int N_DIG     = 4;
  localparam int SCAN_DIV  = 4;
  localparam int GUARD     = 1;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = N_DIG * SCAN_DIV;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] c;
    logic       dp;
    logic       tick;
  } exp_t;

  localparam exp_t DARK = '{an: 4'hF, c: 7'h7F, dp: 1'b1, tick: 1'b0};

  logic CP_1MHz = 1'b0;
  logic nCLR;

  seg_scan_display_if #(.N_DIG(N_DIG)) bus ();

  seg_scan_display #(
    .N_DIG(N_DIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .CP_1MHz (CP_1MHz),
    .nCLR    (nCLR),
    .bus     (bus)
  );

  always #5 CP_1MHz = ~CP_1MHz;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: n counts clock edges since reset release. The output after an edge
  // shows the scan position n had before that edge; everything follows from n by division.
  int          n = 0;
  logic [15:0] m_d;
  logic [3:0]  m_dot, m_blank, m_blink;
  logic        m_lzb;

  function automatic exp_t model_out(input int k, input logic [15:0] d, input logic [3:0] dot,
                                     input logic [3:0] blank, input logic [3:0] blink,
                                     input logic lzb);
    exp_t        e;
    int          c;
    int          slot;
    int          dg;
    bit          off_phase;
    logic [15:0] upper;
    bit          lz;
    bit          on;
    bit          seg_on;
    c         = k % SCAN_DIV;
    slot      = k / SCAN_DIV;
    dg        = slot % N_DIG;
    off_phase = ((slot / BLINK_DIV) % 2) == 1;
    e         = DARK;
    e.tick    = (c == SCAN_DIV - 1);
    if (c >= GUARD) begin
      upper  = d >> (4 * dg);
      lz     = (dg > 0) && (upper == 16'h0);
      on     = !blank[dg] && !(blink[dg] && off_phase);
      seg_on = on && !(lzb && lz);
      e.an   = ~(4'b0001 << dg);
      e.c    = seg_on ? ~FONT[upper[3:0]] : 7'h7F;
      e.dp   = !(on && dot[dg]);
    end
    return e;
  endfunction

  always @(posedge CP_1MHz) begin
    if (!nCLR) begin
      exp_q.push_back(DARK);
      n       = 0;
      m_d     = '0;
      m_dot   = '0;
      m_blank = '0;
      m_blink = '0;
      m_lzb   = 1'b0;
    end else begin
      exp_q.push_back(model_out(n, m_d, m_dot, m_blank, m_blink, m_lzb));
      if (n % FRAME == FRAME - 1) begin
        m_d     = bus.iD;
        m_dot   = bus.DOT;
        m_blank = bus.BLANK;
        m_blink = bus.BLINK;
        m_lzb   = bus.LZB;
      end
      n++;
    end
    n_pushed++;
  end

  // Monitor: every clock presents a new pin state, compared against the oldest expectation.
  always @(negedge CP_1MHz) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_popped++;
      check("AN",        32'(bus.AN),        32'(e.an));
      check("C",         32'(bus.C),         32'(e.c));
      check("DP",        32'(bus.DP),        32'(e.dp));
      check("SCAN_TICK", 32'(bus.SCAN_TICK), 32'(e.tick));
    end
  end

  task automatic run(input int k);
    repeat (k) @(negedge CP_1MHz);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] dot, input logic [3:0] blank,
                       input logic [3:0] blink, input logic lzb);
    bus.iD    = d;
    bus.DOT   = dot;
    bus.BLANK = blank;
    bus.BLINK = blink;
    bus.LZB   = lzb;
  endtask

  task automatic check_dark_now(input string tag);
    check({tag, "_AN"},   32'(bus.AN),        32'(DARK.an));
    check({tag, "_C"},    32'(bus.C),         32'(DARK.c));
    check({tag, "_DP"},   32'(bus.DP),        32'(DARK.dp));
    check({tag, "_TICK"}, 32'(bus.SCAN_TICK), 32'(DARK.tick));
  endtask

  initial begin
    nCLR = 1'b1;
    drive(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #1 nCLR = 1'b0;
    #1 check_dark_now("reset_async");
    run(3);
    nCLR = 1'b1;

    // Frame 0 shows the zero shadow; later frames show 1234 with the digit-2 dot.
    drive(16'h1234, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    run(3 * FRAME);

    // Leading-zero blanking, dot kept on a blanked leading digit.
    drive(16'h0050, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    run(3 * FRAME);

    // Blink on digit 0 only.
    drive(16'h0008, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    run(4 * FRAME);

    // Frame coherence: switch the digits while digit 1 is being shown.
    drive(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(2 * FRAME);
    for (int i = 0; i < FRAME && !((n % FRAME) >= 5 && (n % FRAME) <= 7); i++) run(1);
    drive(16'h2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(2 * FRAME + 4);

    // Reset during the digit-2 slot: pins go dark at once, scanning restarts with zeros.
    for (int i = 0; i < FRAME && (n % FRAME) != 10; i++) run(1);
    nCLR = 1'b0;
    #1 check_dark_now("reset_midrun");
    run(2);
    nCLR = 1'b1;
    run(2 * FRAME);

    // Randomised inputs, changing at arbitrary points, with occasional short resets.
    for (int it = 0; it < 60; it++) begin
      drive(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
            4'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        nCLR = 1'b0;
        run(1);
        nCLR = 1'b1;
      end
      run($urandom_range(1, 40));
    end

    run(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("monitor_kept_up", 32'(n_popped), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
